// File: rtl/alu_share_arbiter.sv
// Arbitrates two valid/ready requesters onto one shared combinational ALU and
// captures the ALU result into a single tagged response register.
module alu_share_arbiter #(
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 5,
  parameter bit PRIO_MODE = 1'b0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iReq0Valid,
  input  logic [CTRL_W-1:0] iReq0Ctrl,
  input  logic [DATA_W-1:0] iReq0A,
  input  logic [DATA_W-1:0] iReq0B,
  output logic              oReq0Ready,
  input  logic              iReq1Valid,
  input  logic [CTRL_W-1:0] iReq1Ctrl,
  input  logic [DATA_W-1:0] iReq1A,
  input  logic [DATA_W-1:0] iReq1B,
  output logic              oReq1Ready,
  output logic [CTRL_W-1:0] oALUCtrl,
  output logic [DATA_W-1:0] oALUA,
  output logic [DATA_W-1:0] oALUB,
  input  logic [DATA_W-1:0] iALUResult,
  input  logic              iALUZero,
  output logic              oRspValid,
  output logic              oRspId,
  output logic [DATA_W-1:0] oRspResult,
  output logic              oRspZero,
  input  logic              iRspReady
);

  // rr_ptr = 0 prefers req0 on contention, 1 prefers req1.
  logic rr_ptr;
  logic slot_free;
  logic grant0;
  logic grant1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    slot_free = !oRspValid || iRspReady;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (slot_free && !iRST) begin
      if (iReq0Valid && iReq1Valid) begin
        if (PRIO_MODE || !rr_ptr) grant0 = 1'b1;
        else                      grant1 = 1'b1;
      end else begin
        grant0 = iReq0Valid;
        grant1 = iReq1Valid;
      end
    end
  end

  assign oReq0Ready = grant0;
  assign oReq1Ready = grant1;

  always_comb begin
    oALUCtrl = '0;
    oALUA    = '0;
    oALUB    = '0;
    if (grant0) begin
      oALUCtrl = iReq0Ctrl;
      oALUA    = iReq0A;
      oALUB    = iReq0B;
    end else if (grant1) begin
      oALUCtrl = iReq1Ctrl;
      oALUA    = iReq1A;
      oALUB    = iReq1B;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oRspValid  <= 1'b0;
      oRspId     <= 1'b0;
      oRspResult <= '0;
      oRspZero   <= 1'b0;
      rr_ptr     <= 1'b0;
    end else if (grant0 || grant1) begin
      oRspValid  <= 1'b1;
      oRspId     <= grant1;
      oRspResult <= iALUResult;
      oRspZero   <= iALUZero;
      rr_ptr     <= grant0;   // point at the requester that lost this cycle
    end else if (iRspReady) begin
      oRspValid  <= 1'b0;     // drain only; data registers keep their value
    end
  end

endmodule
